// File: rtl/master_0_bytes_to_pkts_if.sv
// Byte-in / packet-out bundle for the master_0 bytes-to-packets decoder.
// The master modport is the decoder's view; slave is the surrounding logic.
interface master_0_bytes_to_pkts_if #(
  parameter int CHANNEL_WIDTH = 8
);
  logic                     in_valid;
  logic [7:0]               in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic [7:0]               out_data;
  logic                     out_startofpacket;
  logic                     out_endofpacket;
  logic [CHANNEL_WIDTH-1:0] out_channel;
  logic                     out_ready;
  logic                     drop_pulse;

  modport master (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_startofpacket,
           out_endofpacket, out_channel, drop_pulse
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_startofpacket,
           out_endofpacket, out_channel, drop_pulse
  );
endinterface

// File: rtl/master_0_bytes_to_pkts.sv
// Unescapes a JTAG byte stream into SOP/EOP/channel packets; one-cycle registered output.
// in_ready drops only while a held output byte is stalled by out_ready.
module master_0_bytes_to_pkts #(
  parameter int CHANNEL_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  master_0_bytes_to_pkts_if.master bus
);

  logic                     esc_q,  esc_d;
  logic                     chan_q, chan_d;
  logic                     sop_q,  sop_d;
  logic                     eop_q,  eop_d;
  logic                     pkt_q,  pkt_d;
  logic                     vld_q,  vld_d;
  logic                     osop_q, osop_d;
  logic                     oeop_q, oeop_d;
  logic                     drop_q, drop_d;
  logic [7:0]               dat_q,  dat_d;
  logic [CHANNEL_WIDTH-1:0] ch_q,   ch_d;

  logic       accept;
  logic       is_ctrl;
  logic [7:0] dec;

  assign bus.in_ready = !vld_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign dec          = esc_q ? (bus.in_data ^ 8'h20) : bus.in_data;

  // After 0x7C only an unescaped 0x7D keeps its control meaning.
  always_comb begin
    is_ctrl = 1'b0;
    if (!esc_q) begin
      if (chan_q) is_ctrl = (bus.in_data == 8'h7D);
      else        is_ctrl = (bus.in_data inside {8'h7A, 8'h7B, 8'h7C, 8'h7D});
    end
  end

  always_comb begin
    esc_d  = esc_q;
    chan_d = chan_q;
    sop_d  = sop_q;
    eop_d  = eop_q;
    pkt_d  = pkt_q;
    vld_d  = vld_q && !bus.out_ready;
    osop_d = osop_q;
    oeop_d = oeop_q;
    dat_d  = dat_q;
    ch_d   = ch_q;
    drop_d = 1'b0;
    if (accept) begin
      if (is_ctrl) begin
        case (bus.in_data)
          8'h7A:   sop_d  = 1'b1;
          8'h7B:   eop_d  = 1'b1;
          8'h7C:   chan_d = 1'b1;
          default: esc_d  = 1'b1;
        endcase
      end else begin
        esc_d = 1'b0;
        if (chan_q) begin
          ch_d   = dec[CHANNEL_WIDTH-1:0];
          chan_d = 1'b0;
        end else if (pkt_q || sop_q) begin
          dat_d  = dec;
          osop_d = sop_q;
          oeop_d = eop_q;
          vld_d  = 1'b1;
          sop_d  = 1'b0;
          eop_d  = 1'b0;
          pkt_d  = !eop_q;
        end else begin
          drop_d = 1'b1;
          eop_d  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      esc_q  <= 1'b0;
      chan_q <= 1'b0;
      sop_q  <= 1'b0;
      eop_q  <= 1'b0;
      pkt_q  <= 1'b0;
      vld_q  <= 1'b0;
      osop_q <= 1'b0;
      oeop_q <= 1'b0;
      drop_q <= 1'b0;
      dat_q  <= '0;
      ch_q   <= '0;
    end else begin
      esc_q  <= esc_d;
      chan_q <= chan_d;
      sop_q  <= sop_d;
      eop_q  <= eop_d;
      pkt_q  <= pkt_d;
      vld_q  <= vld_d;
      osop_q <= osop_d;
      oeop_q <= oeop_d;
      drop_q <= drop_d;
      dat_q  <= dat_d;
      ch_q   <= ch_d;
    end
  end

  assign bus.out_valid         = vld_q;
  assign bus.out_data          = dat_q;
  assign bus.out_startofpacket = osop_q;
  assign bus.out_endofpacket   = oeop_q;
  assign bus.out_channel       = ch_q;
  assign bus.drop_pulse        = drop_q;

endmodule
